bullet_sprite_arbiter: RTL and testbench
========================================

// Module: bullet_sprite_arbiter
// PURPOSE
//  Shares the single-port bullet sprite ROM (20x20 texels, 4-bit palette index,
//  400 words, 1-cycle registered read) among N_REQ bullet draw units.
//  Round-robin arbitration issues at most one ROM read per cycle. Each read
//  returns a tagged response after a fixed latency. Sits between per-bullet
//  draw logic and the sprite ROM, ahead of the palette/colour mapper.
// PARAMETERS
//  N_REQ   4   number of requesters (>=2)
//  SPR_W   20  sprite width in texels
//  SPR_H   20  sprite height in texels
//  COORD_W 5   width of texel x/y offsets
//  ADDR_W  19  ROM address width
//  DATA_W  4   ROM data (palette index) width
//  ID_W    2   requester id width, = $clog2(N_REQ)
// PORTS
//  Clk       in   1               system clock, all state on rising edge
//  Reset_n   in   1               asynchronous, active-low reset
//  req       in   N_REQ           per-requester read request, held until granted
//  req_x     in   N_REQ*COORD_W   texel x offset; requester i at [i*COORD_W +: COORD_W]
//  req_y     in   N_REQ*COORD_W   texel y offset; packed the same way as req_x
//  gnt       out  N_REQ           one-hot grant, combinational, same cycle as req
//  rom_addr  out  ADDR_W          registered read address to sprite ROM
//  rom_data  in   DATA_W          ROM output, valid 1 cycle after rom_addr
//  rsp_valid out  1               response strobe, 1 cycle wide
//  rsp_id    out  ID_W            requester index the response belongs to
//  rsp_data  out  DATA_W          palette index; 0 (transparent) when rsp_oob=1
//  rsp_oob   out  1               request had x>=SPR_W or y>=SPR_H
// BEHAVIOUR
//  - Reset (Reset_n=0, async): ptr=0, rom_addr=0, all pipeline valid bits=0.
//    Outputs: rsp_valid=0, rsp_id=0, rsp_oob=0, gnt=0.
//    In-flight reads are discarded; no response is emitted for them after release.
//  - Arbitration: search req starting at index ptr, wrapping modulo N_REQ.
//    The first set bit k gets gnt[k]=1; all other gnt bits are 0.
//  - If req=0, then gnt=0, ptr holds, and rom_addr holds its last value.
//  - On a grant to k, at the clock edge: ptr <= (k+1) mod N_REQ.
//  - Requester rule: on seeing gnt[k], deassert req[k] or present the next
//    coordinates in the following cycle. Coordinates are sampled only in the
//    grant cycle.
//  - Address: addr = y*SPR_W + x, computed at ADDR_W width with no truncation.
//    Maximum in-range value is 399.
//  - Out-of-bounds (x>=SPR_W or y>=SPR_H): the request is still granted and
//    takes its arbitration slot. rom_addr is not updated (holds its last value).
//    rsp_oob=1 and rsp_data=0 at response time.
//  - Pipeline, grant in cycle G:
//      G+1: rom_addr valid; stage-1 registers {valid, id, oob}.
//      G+2: rom_data valid; stage-2 registers {valid, id, oob}.
//    At G+2, rsp_valid = stage-2 valid and rsp_id/rsp_oob come from stage 2.
//    rsp_data = rsp_oob ? 0 : rom_data.
//    Fixed latency of 2 cycles from grant; full throughput of 1 response per
//    cycle; responses return in grant order. No response backpressure.
//  - When rsp_valid=0, rsp_id/rsp_oob hold their last value and rsp_data is
//    don't-care.
//  - Reset asserted mid-stream: gnt drops immediately (combinational on
//    Reset_n). Both stage valids clear; first grant after release goes to index 0.
// TESTING
//  1 Reset: hold Reset_n=0 with req=4'b1111 -> gnt=0, rsp_valid=0, rom_addr=0.
//    Release -> first grant gnt=4'b0001.
//  2 Single read: req[2]=1, x=3, y=2 at cycle G -> gnt=4'b0100 in G.
//    rom_addr=43 in G+1. rsp_valid=1, rsp_id=2, rsp_data=mem[43] in G+2 only.
//  3 Contention: req=4'b1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3.
//    8 back-to-back responses, ids in the same order, no bubbles.
//  4 Fairness: req=4'b1001 held -> grants alternate 0,3,0,3.
//    Then drop req[0] -> requester 3 granted every cycle.
//  5 Bounds: x=19, y=19 -> rom_addr=399.
//    x=20, y=0 -> granted, rom_addr unchanged, rsp_oob=1, rsp_data=0.
//  6 Reset mid-flight: two grants issued, Reset_n=0 for 1 cycle in G+1 ->
//    rsp_valid stays 0 for both; after release ptr=0.

Source files
------------

// File: rtl/bullet_sprite_arbiter_if.sv
// Bundle between bullet draw units, the sprite ROM and the arbiter.
// The slave modport is the arbiter's view of the bundle.
interface bullet_sprite_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int COORD_W = 5,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 4,
    parameter int ID_W    = 2
);
    logic [N_REQ-1:0]         req;
    logic [N_REQ*COORD_W-1:0] req_x;
    logic [N_REQ*COORD_W-1:0] req_y;
    logic [N_REQ-1:0]         gnt;
    logic [ADDR_W-1:0]        rom_addr;
    logic [DATA_W-1:0]        rom_data;
    logic                     rsp_valid;
    logic [ID_W-1:0]          rsp_id;
    logic [DATA_W-1:0]        rsp_data;
    logic                     rsp_oob;

    modport slave (
        input  req, req_x, req_y, rom_data,
        output gnt, rom_addr, rsp_valid, rsp_id, rsp_data, rsp_oob
    );

    modport master (
        output req, req_x, req_y, rom_data,
        input  gnt, rom_addr, rsp_valid, rsp_id, rsp_data, rsp_oob
    );
endinterface

// File: rtl/bullet_sprite_arbiter.sv
// Round-robin arbiter sharing the bullet sprite ROM among draw units.
// Two-stage tagged pipeline returns one response per grant, in order.
module bullet_sprite_arbiter #(
    parameter int N_REQ   = 4,
    parameter int SPR_W   = 20,
    parameter int SPR_H   = 20,
    parameter int COORD_W = 5,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 4,
    parameter int ID_W    = 2
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    bullet_sprite_arbiter_if.slave   bus
);

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               s1_vld_q, s1_vld_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d;
    logic               s1_oob_q, s1_oob_d;
    logic               s2_vld_q, s2_vld_d;
    logic [ID_W-1:0]    s2_id_q, s2_id_d;
    logic               s2_oob_q, s2_oob_d;

    logic               found;
    logic [ID_W-1:0]    gnt_id;
    logic [N_REQ-1:0]   gnt_d;
    logic [COORD_W-1:0] sel_x, sel_y;
    logic [ADDR_W-1:0]  addr_calc;
    logic               oob_calc;
    int                 idx;

    // Round-robin search starting at ptr; grant is masked during reset
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        gnt_d  = '0;
        idx    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr_q) + i) % N_REQ;
            if (Reset_n && !found && bus.req[idx]) begin
                found  = 1'b1;
                gnt_id = ID_W'(idx);
            end
        end
        if (found) begin
            gnt_d[gnt_id] = 1'b1;
        end
    end

    // Winner's coordinates, ROM address and bounds check
    always_comb begin
        sel_x     = bus.req_x[int'(gnt_id)*COORD_W +: COORD_W];
        sel_y     = bus.req_y[int'(gnt_id)*COORD_W +: COORD_W];
        addr_calc = ADDR_W'(sel_y) * ADDR_W'(SPR_W) + ADDR_W'(sel_x);
        oob_calc  = (ADDR_W'(sel_x) >= ADDR_W'(SPR_W)) ||
                    (ADDR_W'(sel_y) >= ADDR_W'(SPR_H));
    end

    // Next-state for pointer, address register and both pipeline stages
    always_comb begin
        ptr_d      = ptr_q;
        rom_addr_d = rom_addr_q;
        s1_vld_d   = found;
        s1_id_d    = s1_id_q;
        s1_oob_d   = s1_oob_q;
        s2_vld_d   = s1_vld_q;
        s2_id_d    = s2_id_q;
        s2_oob_d   = s2_oob_q;
        if (found) begin
            ptr_d    = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
            s1_id_d  = gnt_id;
            s1_oob_d = oob_calc;
            if (!oob_calc) begin
                rom_addr_d = addr_calc;
            end
        end
        if (s1_vld_q) begin
            s2_id_d  = s1_id_q;
            s2_oob_d = s1_oob_q;
        end
    end

    // State registers; reset discards anything in flight
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr_q      <= '0;
            rom_addr_q <= '0;
            s1_vld_q   <= 1'b0;
            s1_id_q    <= '0;
            s1_oob_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_id_q    <= '0;
            s2_oob_q   <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            rom_addr_q <= rom_addr_d;
            s1_vld_q   <= s1_vld_d;
            s1_id_q    <= s1_id_d;
            s1_oob_q   <= s1_oob_d;
            s2_vld_q   <= s2_vld_d;
            s2_id_q    <= s2_id_d;
            s2_oob_q   <= s2_oob_d;
        end
    end

    assign bus.gnt       = gnt_d;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.rsp_valid = s2_vld_q;
    assign bus.rsp_id    = s2_id_q;
    assign bus.rsp_oob   = s2_oob_q;
    assign bus.rsp_data  = s2_oob_q ? '0 : bus.rom_data;

endmodule

// File: tb/tb_bullet_sprite_arbiter.sv
// Testbench for bullet_sprite_arbiter: vector table, directed sequences
// and random traffic against a queue-based response model.
module tb_bullet_sprite_arbiter;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;

    always #5 Clk = ~Clk;

    bullet_sprite_arbiter_if #(
        .N_REQ(4), .COORD_W(5), .ADDR_W(19), .DATA_W(4), .ID_W(2)
    ) bus ();

    bullet_sprite_arbiter #(
        .N_REQ(4), .SPR_W(20), .SPR_H(20), .COORD_W(5),
        .ADDR_W(19), .DATA_W(4), .ID_W(2)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .bus(bus)
    );

    function automatic logic [3:0] memv(input int a);
        return 4'((a * 7 + a / 5 + 3) % 16);
    endfunction

    logic [3:0] mem [512];

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = memv(i);
    end

    // Sprite ROM: one-cycle registered read
    always @(posedge Clk) bus.rom_data <= mem[bus.rom_addr[8:0]];

    typedef struct {
        int due;
        int id;
        bit oob;
        int addr;
    } pend_t;

    pend_t q[$];
    int m_ptr = 0;
    int m_addr = 0;
    int m_id = 0;
    bit m_oob = 0;
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    logic [3:0]  s_gnt;
    logic [18:0] s_addr;
    logic        s_vld;
    logic [1:0]  s_id;
    logic [3:0]  s_data;
    logic        s_oob;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d",
                     name, cyc, act, exp);
        end
    endtask

    task automatic model_check(input logic rn, input logic [3:0] r,
                               input logic [19:0] xs, input logic [19:0] ys);
        int k;
        int x;
        int y;
        bit ob;
        int a;
        s_gnt  = bus.gnt;
        s_addr = bus.rom_addr;
        s_vld  = bus.rsp_valid;
        s_id   = bus.rsp_id;
        s_data = bus.rsp_data;
        s_oob  = bus.rsp_oob;
        if (!rn) begin
            q.delete();
            m_ptr = 0;
            m_addr = 0;
            m_id = 0;
            m_oob = 0;
            chk("rst_gnt", 32'(s_gnt), 0);
            chk("rst_rsp_valid", 32'(s_vld), 0);
            chk("rst_rom_addr", 32'(s_addr), 0);
            chk("rst_rsp_id", 32'(s_id), 0);
            chk("rst_rsp_oob", 32'(s_oob), 0);
        end else begin
            chk("rom_addr", 32'(s_addr), 32'(m_addr));
            if (q.size() > 0 && q[0].due == cyc) begin
                pend_t p;
                p = q.pop_front();
                chk("rsp_valid", 32'(s_vld), 1);
                chk("rsp_id", 32'(s_id), 32'(p.id));
                chk("rsp_oob", 32'(s_oob), 32'(p.oob));
                chk("rsp_data", 32'(s_data), p.oob ? 0 : 32'(memv(p.addr)));
                m_id = p.id;
                m_oob = p.oob;
            end else begin
                chk("rsp_valid_idle", 32'(s_vld), 0);
                chk("rsp_id_hold", 32'(s_id), 32'(m_id));
                chk("rsp_oob_hold", 32'(s_oob), 32'(m_oob));
            end
            k = -1;
            for (int i = 0; i < 4; i++) begin
                if (k < 0 && r[(m_ptr + i) % 4]) k = (m_ptr + i) % 4;
            end
            chk("gnt_model", 32'(s_gnt), k < 0 ? 0 : (1 << k));
            if (k >= 0) begin
                x = int'((xs >> (5 * k)) & 20'd31);
                y = int'((ys >> (5 * k)) & 20'd31);
                ob = (x >= 20) || (y >= 20);
                a = y * 20 + x;
                q.push_back('{cyc + 2, k, ob, a});
                m_ptr = (k + 1) % 4;
                if (!ob) m_addr = a;
            end
        end
        cyc++;
    endtask

    task automatic cycle(input logic rn, input logic [3:0] r,
                         input logic [19:0] xs, input logic [19:0] ys);
        @(negedge Clk);
        Reset_n = rn;
        bus.req = r;
        bus.req_x = xs;
        bus.req_y = ys;
        #1;
        model_check(rn, r, xs, ys);
        @(posedge Clk);
    endtask

    function automatic logic [19:0] at(input int slot, input int v);
        return 20'(v & 31) << (5 * slot);
    endfunction

    typedef struct {
        logic       rn;
        logic [3:0] req;
        logic [4:0] x;
        logic [4:0] y;
        logic [3:0] gnt;
    } vec_t;

    vec_t vecs[15];
    int nv;

    initial begin
        bus.req = '0;
        bus.req_x = '0;
        bus.req_y = '0;

        vecs[0]  = '{1'b0, 4'b1111, 5'd1,  5'd1,  4'b0000};
        vecs[1]  = '{1'b0, 4'b1111, 5'd1,  5'd1,  4'b0000};
        vecs[2]  = '{1'b1, 4'b1111, 5'd0,  5'd0,  4'b0001};
        vecs[3]  = '{1'b1, 4'b1111, 5'd5,  5'd7,  4'b0010};
        vecs[4]  = '{1'b1, 4'b1111, 5'd20, 5'd3,  4'b0100};
        vecs[5]  = '{1'b1, 4'b1111, 5'd19, 5'd0,  4'b1000};
        vecs[6]  = '{1'b1, 4'b1001, 5'd2,  5'd2,  4'b0001};
        vecs[7]  = '{1'b1, 4'b1001, 5'd4,  5'd21, 4'b1000};
        vecs[8]  = '{1'b1, 4'b1001, 5'd9,  5'd9,  4'b0001};
        vecs[9]  = '{1'b1, 4'b1000, 5'd1,  5'd19, 4'b1000};
        vecs[10] = '{1'b1, 4'b1000, 5'd6,  5'd6,  4'b1000};
        vecs[11] = '{1'b1, 4'b0000, 5'd0,  5'd0,  4'b0000};
        vecs[12] = '{1'b1, 4'b0110, 5'd8,  5'd1,  4'b0010};
        vecs[13] = '{1'b1, 4'b0110, 5'd3,  5'd3,  4'b0100};
        vecs[14] = '{1'b1, 4'b0011, 5'd31, 5'd31, 4'b0001};
        nv = 15;

        for (int i = 0; i < nv; i++) begin
            cycle(vecs[i].rn, vecs[i].req,
                  {4{vecs[i].x}}, {4{vecs[i].y}});
            chk("vec_gnt", 32'(s_gnt), 32'(vecs[i].gnt));
        end

        cycle(1'b1, 4'b0000, '0, '0);
        cycle(1'b1, 4'b0000, '0, '0);
        cycle(1'b1, 4'b0000, '0, '0);

        // single read from requester 2
        cycle(1'b1, 4'b0100, at(2, 3), at(2, 2));
        chk("single_gnt", 32'(s_gnt), 32'h4);
        cycle(1'b1, 4'b0000, '0, '0);
        chk("single_addr", 32'(s_addr), 43);
        chk("single_early", 32'(s_vld), 0);
        cycle(1'b1, 4'b0000, '0, '0);
        chk("single_vld", 32'(s_vld), 1);
        chk("single_id", 32'(s_id), 2);
        chk("single_data", 32'(s_data), 32'(memv(43)));
        cycle(1'b1, 4'b0000, '0, '0);
        chk("single_drop", 32'(s_vld), 0);

        // bounds: last texel then x just past the edge
        cycle(1'b1, 4'b0001, at(0, 19), at(0, 19));
        cycle(1'b1, 4'b0001, at(0, 20), at(0, 0));
        chk("bound_addr", 32'(s_addr), 399);
        chk("oob_gnt", 32'(s_gnt), 32'h1);
        cycle(1'b1, 4'b0000, '0, '0);
        chk("oob_addr_hold", 32'(s_addr), 399);
        chk("bound_data", 32'(s_data), 32'(memv(399)));
        cycle(1'b1, 4'b0000, '0, '0);
        chk("oob_vld", 32'(s_vld), 1);
        chk("oob_flag", 32'(s_oob), 1);
        chk("oob_data", 32'(s_data), 0);
        cycle(1'b1, 4'b0000, '0, '0);

        // contention: 8 grants, 8 back-to-back responses
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                cycle(1'b1, 4'b1111, {4{5'd4}}, {4{5'd4}});
                if (s_vld) seen++;
            end
            for (int i = 0; i < 4; i++) begin
                cycle(1'b1, 4'b0000, '0, '0);
                if (s_vld) seen++;
            end
            chk("contention_rsp_count", 32'(seen), 8);
        end

        // reset with two reads in flight
        cycle(1'b1, 4'b1111, {4{5'd2}}, {4{5'd2}});
        cycle(1'b1, 4'b1111, {4{5'd3}}, {4{5'd3}});
        cycle(1'b0, 4'b1111, '0, '0);
        chk("midrst_gnt", 32'(s_gnt), 0);
        cycle(1'b1, 4'b1111, '0, '0);
        chk("midrst_vld_a", 32'(s_vld), 0);
        chk("midrst_first_gnt", 32'(s_gnt), 32'h1);
        cycle(1'b1, 4'b0000, '0, '0);
        chk("midrst_vld_b", 32'(s_vld), 0);
        cycle(1'b1, 4'b0000, '0, '0);
        cycle(1'b1, 4'b0000, '0, '0);

        // random traffic, occasional reset
        for (int i = 0; i < 400; i++) begin
            logic [19:0] xs;
            logic [19:0] ys;
            logic rn;
            xs = '0;
            ys = '0;
            for (int s = 0; s < 4; s++) begin
                xs |= at(s, int'($urandom_range(0, 22)));
                ys |= at(s, int'($urandom_range(0, 22)));
            end
            rn = ($urandom_range(0, 39) != 0);
            cycle(rn, 4'($urandom_range(0, 15)), xs, ys);
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'b0000, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
